fp_dmem_arbiter: RTL

//  Shares the single data-memory port between two FP_Stage lanes. Each lane raises a

---
 rtl/fp_dmem_arbiter_if.sv | 31 +++
 rtl/fp_dmem_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/fp_dmem_arbiter_if.sv
// fp_dmem_arbiter_if: lane request/ack bus plus data-memory port of the FP data-memory arbiter
interface fp_dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic [1:0]          req;
    logic [1:0]          we;
    logic [1:0]          ld;
    logic [2*ADDR_W-1:0] addr;
    logic [2*DATA_W-1:0] wdata;
    logic [1:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                busy;
    logic                gnt_id;
    logic                err;

    modport slave (
        input  req, we, ld, addr, wdata, mem_rdata,
        output ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_id, err
    );

    modport master (
        output req, we, ld, addr, wdata, mem_rdata,
        input  ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt_id, err
    );
endinterface

// File: rtl/fp_dmem_arbiter.sv
// fp_dmem_arbiter: round-robin sharing of one data-memory port between two FP lanes,
// with load-latency wait and 4-phase REQ/ACK return.
module fp_dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int LAT    = 2
) (
    input logic               cp,
    input logic               mr_n,
    fp_dmem_arbiter_if.slave  bus
);
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACKW} state_t;

    state_t        state;
    logic          last;
    logic          l_we;
    logic          l_ld;
    logic [CW-1:0] cnt;
    logic          gnt;

    assign gnt = (bus.req[0] && bus.req[1]) ? ~last : bus.req[1];

    // Memory strobe is raised on the grant edge so it is visible during the ISSUE cycle.
    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            state         <= IDLE;
            last          <= 1'b1;
            l_we          <= 1'b0;
            l_ld          <= 1'b0;
            cnt           <= '0;
            bus.ack       <= '0;
            bus.rdata     <= '0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.busy      <= 1'b0;
            bus.gnt_id    <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|bus.req) begin
                    state         <= ISSUE;
                    bus.busy      <= 1'b1;
                    bus.gnt_id    <= gnt;
                    last          <= gnt;
                    l_we          <= bus.we[gnt];
                    l_ld          <= bus.ld[gnt];
                    bus.mem_en    <= bus.we[gnt] | bus.ld[gnt];
                    bus.mem_we    <= bus.we[gnt];
                    bus.mem_addr  <= gnt ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
                    bus.mem_wdata <= gnt ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
                end
                ISSUE: begin
                    bus.mem_en <= 1'b0;
                    bus.err    <= bus.err | (l_we & l_ld);
                    if (!l_we && l_ld) begin
                        cnt   <= CW'(LAT - 1);
                        state <= WAIT;
                    end else begin
                        bus.ack[bus.gnt_id] <= 1'b1;
                        state               <= ACKW;
                    end
                end
                WAIT: if (cnt == '0) begin
                    bus.rdata           <= bus.mem_rdata;
                    bus.ack[bus.gnt_id] <= 1'b1;
                    state               <= ACKW;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                ACKW: if (!bus.req[bus.gnt_id]) begin
                    bus.ack  <= '0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
